// File: rtl/lfsr_seq_checker_if.sv
// Stream and status bundle between an LFSR sequence source and lfsr_seq_checker.
// The source side drives the qualified bit stream; the checker reports lock and errors.
interface lfsr_seq_checker_if #(
    parameter int ERR_W = 16
);
    logic             in_valid;
    logic             in_bit;
    logic             clr_cnt;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid,
        output in_bit,
        output clr_cnt,
        input  locked,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  in_valid,
        input  in_bit,
        input  clr_cnt,
        output locked,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Self-synchronising LFSR sequence checker: loads received bits until the local
// register predicts LOCK_COUNT bits in a row, then free-runs and counts bit errors.
module lfsr_seq_checker #(
    parameter logic [63:0] LSFR_POLY   = 64'b1110100000000000001,
    parameter int          LOCK_COUNT  = 16,
    parameter int          WINDOW      = 256,
    parameter int          LOSS_THRESH = 8,
    parameter int          ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    lfsr_seq_checker_if.slave bus
);
    localparam int LSFR_SIZE = $clog2(LSFR_POLY);
    localparam int FILL_W    = $clog2(LSFR_SIZE + 1);
    localparam int GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W     = $clog2(WINDOW + 1);
    localparam int WERR_W    = $clog2(LOSS_THRESH + 1);

    localparam logic [LSFR_SIZE-1:0] POLY_MASK  = LSFR_SIZE'(LSFR_POLY);
    localparam logic [LSFR_SIZE-1:0] SREG_ZERO  = {LSFR_SIZE{1'b0}};
    localparam logic [FILL_W-1:0]    FILL_ZERO  = {FILL_W{1'b0}};
    localparam logic [FILL_W-1:0]    FILL_ONE   = FILL_W'(1'b1);
    localparam logic [FILL_W-1:0]    FILL_FULL  = FILL_W'(LSFR_SIZE);
    localparam logic [GOOD_W-1:0]    GOOD_ZERO  = {GOOD_W{1'b0}};
    localparam logic [GOOD_W-1:0]    GOOD_ONE   = GOOD_W'(1'b1);
    localparam logic [GOOD_W-1:0]    GOOD_LOCK  = GOOD_W'(LOCK_COUNT);
    localparam logic [WIN_W-1:0]     WIN_ZERO   = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]     WIN_ONE    = WIN_W'(1'b1);
    localparam logic [WIN_W-1:0]     WIN_END    = WIN_W'(WINDOW);
    localparam logic [WERR_W-1:0]    WERR_ZERO  = {WERR_W{1'b0}};
    localparam logic [WERR_W-1:0]    WERR_ONE   = WERR_W'(1'b1);
    localparam logic [WERR_W-1:0]    WERR_LOSS  = WERR_W'(LOSS_THRESH);
    localparam logic [ERR_W-1:0]     ERR_ZERO   = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0]     ERR_ONE    = ERR_W'(1'b1);
    localparam logic [ERR_W-1:0]     ERR_MAX    = {ERR_W{1'b1}};

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Parity of the tapped register bits: the next bit the generator will emit.
    function automatic logic pred_fn(input logic [LSFR_SIZE-1:0] sreg);
        return ^(sreg & POLY_MASK);
    endfunction

    state_t               state_r, state_s;
    logic [LSFR_SIZE-1:0] sreg_r,  sreg_s;
    logic [FILL_W-1:0]    fill_r,  fill_s;
    logic [GOOD_W-1:0]    good_r,  good_s;
    logic [WIN_W-1:0]     win_r,   win_s;
    logic [WERR_W-1:0]    werr_r,  werr_s;
    logic [ERR_W-1:0]     err_cnt_r, err_cnt_s;
    logic                 locked_r, locked_s;
    logic                 err_pulse_r, err_pulse_s;
    logic                 err_inc_s;
    logic                 pred_s;
    logic                 miss_s;

    // Next-state, counter and output decode for one qualified bit.
    always_comb begin
        state_s     = state_r;
        sreg_s      = sreg_r;
        fill_s      = fill_r;
        good_s      = good_r;
        win_s       = win_r;
        werr_s      = werr_r;
        err_pulse_s = 1'b0;
        err_inc_s   = 1'b0;
        pred_s      = pred_fn(sreg_r);
        miss_s      = bus.in_bit ^ pred_s;

        if (bus.in_valid) begin
            case (state_r)
                ST_SEARCH: begin
                    sreg_s = {sreg_r[LSFR_SIZE-2:0], bus.in_bit};
                    if (fill_r < FILL_FULL) begin
                        fill_s = fill_r + FILL_ONE;
                    end else if (!miss_s && (sreg_r != SREG_ZERO)) begin
                        // All-zero register is excluded so a stuck-at-0 line never locks.
                        good_s = good_r + GOOD_ONE;
                        if (good_s == GOOD_LOCK) begin
                            state_s = ST_LOCKED;
                            win_s   = WIN_ZERO;
                            werr_s  = WERR_ZERO;
                        end else begin
                            state_s = ST_SEARCH;
                        end
                    end else begin
                        good_s = GOOD_ZERO;
                    end
                end
                ST_LOCKED: begin
                    // Free-run on the prediction so corrupted input bits do not propagate.
                    sreg_s = {sreg_r[LSFR_SIZE-2:0], pred_s};
                    win_s  = win_r + WIN_ONE;
                    if (miss_s) begin
                        err_pulse_s = 1'b1;
                        err_inc_s   = 1'b1;
                        werr_s      = werr_r + WERR_ONE;
                    end else begin
                        err_pulse_s = 1'b0;
                    end
                    if (werr_s == WERR_LOSS) begin
                        state_s = ST_SEARCH;
                        fill_s  = FILL_ZERO;
                        good_s  = GOOD_ZERO;
                        win_s   = WIN_ZERO;
                        werr_s  = WERR_ZERO;
                    end else if (win_s == WIN_END) begin
                        win_s  = WIN_ZERO;
                        werr_s = WERR_ZERO;
                    end else begin
                        state_s = ST_LOCKED;
                    end
                end
                default: begin
                    state_s = ST_SEARCH;
                end
            endcase
        end else begin
            err_pulse_s = 1'b0;
        end

        // Clear beats a same-cycle increment; the count saturates instead of wrapping.
        err_cnt_s = bus.clr_cnt ? ERR_ZERO :
                    (err_inc_s && (err_cnt_r != ERR_MAX)) ? (err_cnt_r + ERR_ONE) :
                    err_cnt_r;
        locked_s  = (state_s == ST_LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_SEARCH;
            sreg_r      <= SREG_ZERO;
            fill_r      <= FILL_ZERO;
            good_r      <= GOOD_ZERO;
            win_r       <= WIN_ZERO;
            werr_r      <= WERR_ZERO;
            err_cnt_r   <= ERR_ZERO;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sreg_r      <= sreg_s;
            fill_r      <= fill_s;
            good_r      <= good_s;
            win_r       <= win_s;
            werr_r      <= werr_s;
            err_cnt_r   <= err_cnt_s;
            locked_r    <= locked_s;
            err_pulse_r <= err_pulse_s;
        end
    end

    assign bus.locked    = locked_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_cnt_r;
endmodule
